// File: rtl/debounce_pulse.sv
// Debounces a raw push-button into a clean level and one single-cycle press strobe.
// Latency: 2 synchroniser cycles plus STABLE_COUNT+... i.e. outputs move at edge STABLE_COUNT+2 after the pin settles.
// No backpressure: free-running, one PULSE per accepted press regardless of hold time.
module debounce_pulse #(
    parameter logic ACTIVE_LOW   = 1'b1,
    parameter int   STABLE_COUNT = 1000000,
    parameter int   CNT_WIDTH    = 20
) (
    input  logic CLOCK,
    input  logic RESET,
    input  logic BUTTON_IN,
    output logic PULSE,
    output logic LEVEL
);

    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    // Terminal count: the counter reaches this value after STABLE_COUNT-1
    // increments, so the accepting edge is the STABLE_COUNT-th stable sample.
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(STABLE_COUNT - 1);

    logic                 sync1_q;
    logic                 sync2_q;
    logic                 pressed;
    logic                 cnt_at_max;
    state_t               state_q;
    state_t               state_d;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;
    logic                 pulse_q;
    logic                 pulse_d;
    logic                 level_q;
    logic                 level_d;

    // Two-flop synchroniser; resets to the released pin level so reset never
    // looks like a press edge.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            sync1_q <= ACTIVE_LOW;
            sync2_q <= ACTIVE_LOW;
        end else begin
            sync1_q <= BUTTON_IN;
            sync2_q <= sync1_q;
        end
    end

    // Normalised input: 1 means the button is pressed whatever the pin polarity.
    assign pressed    = sync2_q ^ ACTIVE_LOW;
    assign cnt_at_max = (cnt_q == CNT_MAX);

    // Debounce next-state, stability counter and output decode.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pulse_d = 1'b0;
        unique case (state_q)
            RELEASED: begin
                cnt_d = '0;
                if (pressed) begin
                    state_d = PRESS_WAIT;
                end
            end
            PRESS_WAIT: begin
                if (!pressed) begin
                    // Bounce during press: drop back silently.
                    state_d = RELEASED;
                    cnt_d   = '0;
                end else if (cnt_at_max) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                    pulse_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            PRESSED: begin
                cnt_d = '0;
                if (!pressed) begin
                    state_d = RELEASE_WAIT;
                end
            end
            RELEASE_WAIT: begin
                if (pressed) begin
                    // Release bounce: still the same press, no new strobe.
                    state_d = PRESSED;
                    cnt_d   = '0;
                end else if (cnt_at_max) begin
                    state_d = RELEASED;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = RELEASED;
                cnt_d   = '0;
            end
        endcase
        // Level follows the state being entered so it moves on the same edge
        // as the strobe.
        level_d = (state_d == PRESSED) || (state_d == RELEASE_WAIT);
    end

    // FSM state, counter and registered outputs.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_q <= RELEASED;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
            level_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
            level_q <= level_d;
        end
    end

    assign PULSE = pulse_q;
    assign LEVEL = level_q;

endmodule

// File: tb/tb_debounce_pulse.sv
// Directed bench for debounce_pulse with STABLE_COUNT=4, ACTIVE_LOW=1, CNT_WIDTH=3.
// Inputs change 1 time unit after a rising edge; outputs are sampled at the same point.
// A downstream 8-bit counter model is fed from PULSE and cleared by RESET.
module tb_debounce_pulse;

    logic CLOCK = 1'b0;
    logic RESET;
    logic BUTTON_IN;
    logic PULSE;
    logic LEVEL;

    int errors = 0;
    int checks = 0;
    int pulse_total = 0;
    int dbl_pulse = 0;
    int max_cnt = 0;
    int base = 0;
    logic prev_pulse = 1'b0;
    logic [7:0] ctr_q = 8'd0;

    always #5 CLOCK = ~CLOCK;

    debounce_pulse #(
        .ACTIVE_LOW  (1'b1),
        .STABLE_COUNT(4),
        .CNT_WIDTH   (3)
    ) dut (
        .CLOCK    (CLOCK),
        .RESET    (RESET),
        .BUTTON_IN(BUTTON_IN),
        .PULSE    (PULSE),
        .LEVEL    (LEVEL)
    );

    // Mid-cycle monitor: pulse tally, back-to-back detection, counter model.
    always @(negedge CLOCK) begin
        if (PULSE === 1'b1) begin
            pulse_total = pulse_total + 1;
            ctr_q = ctr_q + 8'd1;
        end
        if (PULSE === 1'b1 && prev_pulse === 1'b1) dbl_pulse = dbl_pulse + 1;
        prev_pulse = PULSE;
        if (RESET === 1'b1) ctr_q = 8'd0;
        if (int'(dut.cnt_q) > max_cnt) max_cnt = int'(dut.cnt_q);
    end

    task automatic tick();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic check(input string tag, input int act, input int req);
        checks = checks + 1;
        if (act !== req) begin
            errors = errors + 1;
            $display("FAIL %s: got %0d expected %0d", tag, act, req);
        end
    endtask

    initial begin
        RESET = 1'b1;
        BUTTON_IN = 1'b1;
        tick();
        tick();
        check("rst_pulse", int'(PULSE), 0);
        check("rst_level", int'(LEVEL), 0);
        check("rst_state", int'(dut.state_q), 0);
        check("rst_cnt", int'(dut.cnt_q), 0);
        check("rst_sync1", int'(dut.sync1_q), 1);
        check("rst_sync2", int'(dut.sync2_q), 1);

        // Clean press: pin changes before edge 0, strobe at edge 6.
        base = pulse_total;
        RESET = 1'b0;
        BUTTON_IN = 1'b0;
        repeat (6) begin
            tick();
            check("clean_no_early_pulse", int'(PULSE), 0);
        end
        check("clean_no_early_level", int'(LEVEL), 0);
        tick();
        check("clean_pulse", int'(PULSE), 1);
        check("clean_level_rise", int'(LEVEL), 1);
        check("clean_state_pressed", int'(dut.state_q), 2);
        tick();
        check("clean_pulse_one_cycle", int'(PULSE), 0);
        check("clean_level_held", int'(LEVEL), 1);
        repeat (12) tick();
        check("clean_single_pulse", pulse_total - base, 1);
        check("clean_level_still", int'(LEVEL), 1);

        // Clean release: level falls at edge 6.
        BUTTON_IN = 1'b1;
        repeat (6) tick();
        check("release_level_hold", int'(LEVEL), 1);
        tick();
        check("release_level_fall", int'(LEVEL), 0);
        check("release_state", int'(dut.state_q), 0);
        repeat (4) tick();

        // Bouncy press: 0,1,0,1 then hold 0; strobe 6 edges after final settle.
        base = pulse_total;
        BUTTON_IN = 1'b0; tick();
        BUTTON_IN = 1'b1; tick();
        BUTTON_IN = 1'b0; tick();
        BUTTON_IN = 1'b1; tick();
        BUTTON_IN = 1'b0;
        repeat (6) tick();
        check("bouncy_no_early_pulse", int'(PULSE), 0);
        check("bouncy_no_early_count", pulse_total - base, 0);
        tick();
        check("bouncy_pulse", int'(PULSE), 1);
        repeat (8) tick();
        check("bouncy_single_pulse", pulse_total - base, 1);
        check("bouncy_level", int'(LEVEL), 1);

        // Release bounce from PRESSED: high 2, low 2, then high for good.
        base = pulse_total;
        BUTTON_IN = 1'b1; tick(); tick();
        BUTTON_IN = 1'b0; tick(); tick();
        check("relbounce_state_rw", int'(dut.state_q), 3);
        check("relbounce_cnt", int'(dut.cnt_q), 1);
        BUTTON_IN = 1'b1;
        repeat (6) tick();
        check("relbounce_level_hold", int'(LEVEL), 1);
        check("relbounce_cnt_max", int'(dut.cnt_q), 3);
        tick();
        check("relbounce_level_fall", int'(LEVEL), 0);
        repeat (4) tick();
        check("relbounce_no_pulse", pulse_total - base, 0);

        // Short glitch of 3 cycles.
        base = pulse_total;
        BUTTON_IN = 1'b0;
        repeat (3) tick();
        check("glitch3_state_pw", int'(dut.state_q), 1);
        BUTTON_IN = 1'b1;
        repeat (10) tick();
        check("glitch3_no_pulse", pulse_total - base, 0);
        check("glitch3_level", int'(LEVEL), 0);

        // Glitch of exactly STABLE_COUNT pin cycles is still rejected.
        base = pulse_total;
        BUTTON_IN = 1'b0;
        repeat (4) tick();
        BUTTON_IN = 1'b1;
        repeat (10) tick();
        check("glitch4_no_pulse", pulse_total - base, 0);
        check("glitch4_level", int'(LEVEL), 0);

        // Five pin cycles is the shortest accepted press.
        base = pulse_total;
        BUTTON_IN = 1'b0;
        repeat (5) tick();
        BUTTON_IN = 1'b1;
        tick();
        tick();
        check("press5_pulse", int'(PULSE), 1);
        repeat (12) tick();
        check("press5_single_pulse", pulse_total - base, 1);
        check("press5_level_back", int'(LEVEL), 0);

        // Reset two cycles after entering PRESS_WAIT.
        base = pulse_total;
        BUTTON_IN = 1'b0;
        repeat (3) tick();
        check("rstmid_state_pw", int'(dut.state_q), 1);
        repeat (2) tick();
        check("rstmid_cnt_before", int'(dut.cnt_q), 2);
        RESET = 1'b1;
        tick();
        check("rstmid_state", int'(dut.state_q), 0);
        check("rstmid_cnt", int'(dut.cnt_q), 0);
        check("rstmid_sync1", int'(dut.sync1_q), 1);
        check("rstmid_sync2", int'(dut.sync2_q), 1);
        check("rstmid_pulse", int'(PULSE), 0);
        check("rstmid_level", int'(LEVEL), 0);
        tick();
        check("rstmid_pulse_hold", int'(PULSE), 0);
        check("rstmid_no_pulse", pulse_total - base, 0);
        RESET = 1'b0;
        repeat (6) tick();
        check("rstheld_no_early_pulse", int'(PULSE), 0);
        tick();
        check("rstheld_pulse", int'(PULSE), 1);
        check("rstheld_level", int'(LEVEL), 1);
        repeat (4) tick();
        check("rstheld_single_pulse", pulse_total - base, 1);
        BUTTON_IN = 1'b1;
        repeat (10) tick();
        check("rstheld_release", int'(LEVEL), 0);

        // Counter integration: five separated presses.
        RESET = 1'b1;
        tick();
        tick();
        RESET = 1'b0;
        check("ctr_cleared", int'(ctr_q), 0);
        for (int i = 0; i < 5; i++) begin
            BUTTON_IN = 1'b0;
            repeat (10) tick();
            BUTTON_IN = 1'b1;
            repeat (10) tick();
        end
        check("ctr_q_five", int'(ctr_q), 5);

        check("no_back_to_back_pulse", dbl_pulse, 0);
        check("cnt_peak", max_cnt, 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
